// File: rtl/md5_pkg.sv
// ----------------------------------------------------------------------------
// md5_pkg : shared MD5 message-padding types and constants
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package md5_pkg;

  typedef logic [31:0] md5_word_t;

  typedef enum logic [2:0] {
    FILL = 3'd0,
    PAD  = 3'd1,
    ZERO = 3'd2,
    LEN  = 3'd3,
    EMIT = 3'd4
  } pad_state_t;

  localparam logic [7:0] MD5_PAD_BYTE   = 8'h80;
  localparam int         MD5_BLK_BYTES  = 64;
  localparam int         MD5_LEN_OFFSET = 56;

endpackage : md5_pkg

`default_nettype wire

// File: rtl/md5_msg_padder_if.sv
// ----------------------------------------------------------------------------
// md5_msg_padder_if : byte-in / 512-bit-block-out handshake bundle
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface md5_msg_padder_if #(
  parameter int n = 32
);
  logic                  byte_valid_i;
  logic [7:0]            byte_i;
  logic                  byte_last_i;
  logic                  empty_i;
  logic                  byte_ready_o;
  logic [0:15][n-1:0]    M_o;
  logic                  blk_valid_o;
  logic                  blk_last_o;
  logic                  blk_ready_i;

  modport master (
    output byte_i, byte_valid_i, byte_last_i, empty_i, blk_ready_i,
    input  byte_ready_o, M_o, blk_valid_o, blk_last_o
  );

  modport slave (
    input  byte_i, byte_valid_i, byte_last_i, empty_i, blk_ready_i,
    output byte_ready_o, M_o, blk_valid_o, blk_last_o
  );
endinterface : md5_msg_padder_if

`default_nettype wire

// File: rtl/md5_blk_buf.sv
// ----------------------------------------------------------------------------
// md5_blk_buf : 64-byte block buffer, byte write at index, length-field write,
//               synchronous clear, flat little-endian byte view
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module md5_blk_buf
  import md5_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [5:0]                   wr_idx,
  input  logic [7:0]                   wr_data,
  input  logic                         len_wr,
  input  logic [LEN_W-1:0]             len_val,
  output logic [MD5_BLK_BYTES*8-1:0]   blk
);

  localparam int c_len_bytes = LEN_W / 8;
  localparam int c_len_base  = MD5_BLK_BYTES - c_len_bytes;

  logic [7:0] r_mem [0:MD5_BLK_BYTES-1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < MD5_BLK_BYTES; i++) r_mem[i] <= 8'h00;
    end else begin
      if (wr_en) r_mem[wr_idx] <= wr_data;
      // length field occupies the tail of the block, least-significant byte first
      if (len_wr) begin
        for (int i = 0; i < c_len_bytes; i++) r_mem[c_len_base + i] <= len_val[8*i +: 8];
      end
    end
  end

  generate
    for (genvar g = 0; g < MD5_BLK_BYTES; g++) begin : g_byte
      assign blk[8*g +: 8] = r_mem[g];
    end
  endgenerate

endmodule : md5_blk_buf

`default_nettype wire

// File: rtl/md5_msg_padder.sv
// ----------------------------------------------------------------------------
// md5_msg_padder : MD5 padding front end, bytes in, 512-bit blocks out.
//                  Optional block counter output enabled by MD5_PAD_BLKCNT_EN.
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module md5_msg_padder
  import md5_pkg::*;
#(
  parameter int n     = 32,
  parameter int LEN_W = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  md5_msg_padder_if.slave    bus
`ifdef MD5_PAD_BLKCNT_EN
  ,
  output logic [31:0]        blk_cnt_o
`endif
);

  localparam int CNT_W = LEN_W - 3;

  localparam logic [2:0] ST_FILL = FILL;
  localparam logic [2:0] ST_PAD  = PAD;
  localparam logic [2:0] ST_ZERO = ZERO;
  localparam logic [2:0] ST_LEN  = LEN;
  localparam logic [2:0] ST_EMIT = EMIT;

  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [5:0]       c_idx_last = 6'(MD5_BLK_BYTES - 1);
  localparam logic [5:0]       c_idx_len  = 6'(MD5_LEN_OFFSET);

  logic [2:0]       r_state;
  logic [5:0]       r_idx;
  logic [CNT_W-1:0] r_count;
  logic             r_pad_pend;
  logic             r_ovf;
  logic             r_blk_valid;
  logic             r_last;

  logic             w_hs;
  logic             w_wr_en;
  logic [7:0]       w_wr_data;
  logic             w_len_wr;
  logic [LEN_W-1:0] w_bitlen;
  logic [MD5_BLK_BYTES*8-1:0] w_blk;

  assign w_hs     = r_blk_valid & bus.blk_ready_i;
  assign w_bitlen = {r_count, 3'b000};
  assign w_len_wr = (r_state == ST_LEN);

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = 8'h00;
    case (r_state)
      ST_FILL: begin
        w_wr_en   = bus.byte_valid_i;
        w_wr_data = bus.byte_i;
      end
      ST_PAD: begin
        w_wr_en   = 1'b1;
        w_wr_data = MD5_PAD_BYTE;
      end
      ST_ZERO: w_wr_en = (r_idx != c_idx_len);
      default: ;
    endcase
  end

  md5_blk_buf #(.LEN_W(LEN_W)) u_buf (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (w_hs),
    .wr_en   (w_wr_en),
    .wr_idx  (r_idx),
    .wr_data (w_wr_data),
    .len_wr  (w_len_wr),
    .len_val (w_bitlen),
    .blk     (w_blk)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_FILL;
      r_idx       <= 6'd0;
      r_count     <= '0;
      r_pad_pend  <= 1'b0;
      r_ovf       <= 1'b0;
      r_blk_valid <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (bus.byte_valid_i) begin
            r_idx   <= r_idx + 6'd1;
            r_count <= r_count + c_cnt_one;
            if (r_idx == c_idx_last) begin
              r_state     <= ST_EMIT;
              r_blk_valid <= 1'b1;
              r_pad_pend  <= bus.byte_last_i;
            end else if (bus.byte_last_i) begin
              r_state <= ST_PAD;
            end
          end else if (bus.empty_i && r_idx == 6'd0 && r_count == '0) begin
            r_state <= ST_PAD;
          end
        end
        ST_PAD: begin
          r_idx <= r_idx + 6'd1;
          // 0x80 landing on the final byte leaves no room for zeros or length
          if (r_idx == c_idx_last) begin
            r_state     <= ST_EMIT;
            r_blk_valid <= 1'b1;
            r_ovf       <= 1'b1;
          end else begin
            r_state <= ST_ZERO;
          end
        end
        ST_ZERO: begin
          if (r_idx == c_idx_len) begin
            r_state <= ST_LEN;
          end else begin
            r_idx <= r_idx + 6'd1;
            if (r_idx == c_idx_last) begin
              r_state     <= ST_EMIT;
              r_blk_valid <= 1'b1;
              r_ovf       <= 1'b1;
            end
          end
        end
        ST_LEN: begin
          r_state     <= ST_EMIT;
          r_blk_valid <= 1'b1;
          r_last      <= 1'b1;
        end
        ST_EMIT: begin
          if (w_hs) begin
            r_blk_valid <= 1'b0;
            r_idx       <= 6'd0;
            r_last      <= 1'b0;
            if (r_last) begin
              r_state <= ST_FILL;
              r_count <= '0;
            end else if (r_pad_pend) begin
              r_state    <= ST_PAD;
              r_pad_pend <= 1'b0;
            end else if (r_ovf) begin
              r_state <= ST_ZERO;
              r_ovf   <= 1'b0;
            end else begin
              r_state <= ST_FILL;
            end
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign bus.byte_ready_o = (r_state == ST_FILL);
  assign bus.blk_valid_o  = r_blk_valid;
  assign bus.blk_last_o   = r_last;

  generate
    for (genvar g = 0; g < 16; g++) begin : g_word
      assign bus.M_o[g] = w_blk[g*n +: n];
    end
  endgenerate

`ifdef MD5_PAD_BLKCNT_EN
  logic [31:0] r_blk_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)     r_blk_cnt <= 32'd0;
    else if (w_hs) r_blk_cnt <= r_blk_cnt + 32'd1;
  end

  assign blk_cnt_o = r_blk_cnt;
`endif

endmodule : md5_msg_padder

`default_nettype wire

// File: tb/tb_md5_msg_padder.sv
// ----------------------------------------------------------------------------
// tb_md5_msg_padder : directed self-checking bench for md5_msg_padder
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_md5_msg_padder;
  import md5_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md5_msg_padder_if #(.n(32)) bus ();

`ifdef MD5_PAD_BLKCNT_EN
  logic [31:0] blk_cnt;
`endif

  md5_msg_padder #(.n(32), .LEN_W(64)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef MD5_PAD_BLKCNT_EN
    ,
    .blk_cnt_o (blk_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  md5_word_t exp_w [0:15];
  logic [0:15][31:0] snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 16; k++) exp_w[k] = 32'h0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge clk);
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    bus.byte_last_i  = last;
    @(posedge clk);
    #1;
    bus.byte_valid_i = 1'b0;
    bus.byte_last_i  = 1'b0;
  endtask

  task automatic wait_blk(input string tag);
    int cyc = 0;
    while (bus.blk_valid_o !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_valid"}, 64'(bus.blk_valid_o), 64'd1);
  endtask

  task automatic chk_block(input string tag, input logic last);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s_w%0d", tag, k), 64'(bus.M_o[k]), 64'(exp_w[k]));
    chk({tag, "_last"}, 64'(bus.blk_last_o), 64'(last));
  endtask

  task automatic take_blk(input string tag);
    @(negedge clk);
    bus.blk_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.blk_ready_i = 1'b0;
    chk({tag, "_drop"}, 64'(bus.blk_valid_o), 64'd0);
  endtask

  initial begin
    bus.byte_i       = 8'h00;
    bus.byte_valid_i = 1'b0;
    bus.byte_last_i  = 1'b0;
    bus.empty_i      = 1'b0;
    bus.blk_ready_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_valid", 64'(bus.blk_valid_o), 64'd0);
    chk("rst_last",  64'(bus.blk_last_o),  64'd0);
    chk("rst_ready", 64'(bus.byte_ready_o), 64'd1);
    chk("rst_m_lo",  64'(bus.M_o[0:1]),    64'd0);
    chk("rst_m_hi",  64'(bus.M_o[14:15]),  64'd0);

    // "abc"
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    chk("abc_busy", 64'(bus.byte_ready_o), 64'd0);
    wait_blk("abc");
    clear_exp();
    exp_w[0]  = 32'h80636261;
    exp_w[14] = 32'h00000018;
    chk_block("abc", 1'b1);
    take_blk("abc");
    chk("abc_clr", 64'(bus.M_o[0]), 64'd0);
    chk("abc_rdy", 64'(bus.byte_ready_o), 64'd1);

    // zero-length message
    @(negedge clk);
    bus.empty_i = 1'b1;
    @(posedge clk);
    #1;
    bus.empty_i = 1'b0;
    wait_blk("empty");
    clear_exp();
    exp_w[0] = 32'h00000080;
    chk_block("empty", 1'b1);
    take_blk("empty");

    // 55 zero bytes: padding and length fit exactly
    for (int i = 0; i < 55; i++) send_byte(8'h00, i == 54);
    wait_blk("b55");
    clear_exp();
    exp_w[13] = 32'h80000000;
    exp_w[14] = 32'h000001B8;
    chk_block("b55", 1'b1);
    take_blk("b55");

    // 56 zero bytes: length spills into a second block
    for (int i = 0; i < 56; i++) send_byte(8'h00, i == 55);
    wait_blk("b56a");
    clear_exp();
    exp_w[14] = 32'h00000080;
    chk_block("b56a", 1'b0);
    take_blk("b56a");
    wait_blk("b56b");
    clear_exp();
    exp_w[14] = 32'h000001C0;
    chk_block("b56b", 1'b1);
    take_blk("b56b");

    // 64 bytes of value i: pure data block, then pad-only block
    for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63);
    wait_blk("b64a");
    for (int k = 0; k < 16; k++)
      exp_w[k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    chk_block("b64a", 1'b0);
    take_blk("b64a");
    wait_blk("b64b");
    clear_exp();
    exp_w[0]  = 32'h00000080;
    exp_w[14] = 32'h00000200;
    chk_block("b64b", 1'b1);
    take_blk("b64b");

    // back-pressure: block held, bytes refused
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    wait_blk("stall");
    snap = bus.M_o;
    bus.byte_i       = 8'hFF;
    bus.byte_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall_m%0d", c), 64'(bus.M_o == snap), 64'd1);
      chk($sformatf("stall_l%0d", c), 64'(bus.blk_last_o), 64'd1);
      chk($sformatf("stall_v%0d", c), 64'(bus.blk_valid_o), 64'd1);
      chk($sformatf("stall_r%0d", c), 64'(bus.byte_ready_o), 64'd0);
    end
    bus.byte_valid_i = 1'b0;
    chk("stall_w14", 64'(bus.M_o[14]), 64'h18);

    // reset while a block is waiting
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rste_valid", 64'(bus.blk_valid_o), 64'd0);
    chk("rste_m0",    64'(bus.M_o[0]),      64'd0);
    chk("rste_m14",   64'(bus.M_o[14]),     64'd0);
    chk("rste_ready", 64'(bus.byte_ready_o), 64'd1);
    rst = 1'b0;

    // reset mid-message discards the partial count
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
    wait_blk("abc2");
    clear_exp();
    exp_w[0]  = 32'h80636261;
    exp_w[14] = 32'h00000018;
    chk_block("abc2", 1'b1);
`ifdef MD5_PAD_BLKCNT_EN
    chk("blkcnt", 64'(blk_cnt), 64'd0);
`endif
    take_blk("abc2");
`ifdef MD5_PAD_BLKCNT_EN
    chk("blkcnt1", 64'(blk_cnt), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_md5_msg_padder

`default_nettype wire
